// File: rtl/fl1p3_scan_seq.sv
// fl1p3_scan_seq: scan-chain sequencer for a bank of FL1P3IY-style mux-input flops.
// Latency: accept -> CAP_VALID after WIDTH edges (shift only) or WIDTH+1 edges (capture + shift).
// Backpressure: holds CAP_VALID/CAP_DATA with SP=0 until CAP_READY; no new request while holding.
//
// Ports:
//   CK, CD                      clock, asynchronous active-high reset
//   LOAD_VALID/READY/DATA/MODE  request: word to scan in, MODE=1 adds one D0 capture cycle first
//   SD, SP, SI                  chain select (1=scan path), chain clock enable, serial data into flop 0
//   SO                          serial data out of the last chain flop
//   CAP_VALID/READY/DATA        previous chain contents, bit k = old flop k
//
// WIDTH must be at least 2.
module fl1p3_scan_seq #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             CK,
   input  logic             CD,
   input  logic             LOAD_VALID,
   output logic             LOAD_READY,
   input  logic [WIDTH-1:0] LOAD_DATA,
   input  logic             LOAD_MODE,
   output logic             SD,
   output logic             SP,
   output logic             SI,
   input  logic             SO,
   output logic             CAP_VALID,
   input  logic             CAP_READY,
   output logic [WIDTH-1:0] CAP_DATA
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CAPT  = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_nxt;

   logic [WIDTH-1:0] r_sh;     // outgoing word, MSB presented on SI
   logic [WIDTH-1:0] r_cap;    // incoming chain contents
   logic [CW-1:0]    r_cnt;    // shift cycle index 0..WIDTH-1
   logic             r_sd;
   logic             r_sp;
   logic             r_rdy;
   logic             r_cvld;

   logic             w_acc;
   logic             w_last;

   // r_rdy is high exactly in IDLE, so this is the request handshake.
   assign w_acc  = r_rdy & LOAD_VALID;
   assign w_last = (r_cnt == CW'(WIDTH - 1));

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge CK or posedge CD) begin
      if (CD) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_acc) begin
               w_nxt = LOAD_MODE ? CAPT : SHIFT;
            end
         end
         CAPT: begin
            w_nxt = SHIFT;
         end
         SHIFT: begin
            if (w_last) begin
               w_nxt = HOLD;
            end
         end
         HOLD: begin
            if (CAP_READY) begin
               w_nxt = IDLE;
            end
         end
         default: begin
            w_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Registered outputs and datapath
   // Chain controls are decoded from the next state so that they line up
   // with the state the block is entering, while still leaving a flop.
   // ------------------------------------------------------------------
   always_ff @(posedge CK or posedge CD) begin
      if (CD) begin
         r_sd   <= 1'b0;
         r_sp   <= 1'b0;
         r_rdy  <= 1'b1;
         r_cvld <= 1'b0;
         r_sh   <= '0;
         r_cap  <= '0;
         r_cnt  <= '0;
      end else begin
         r_sd   <= (w_nxt == SHIFT);
         r_sp   <= (w_nxt == SHIFT) || (w_nxt == CAPT);
         r_rdy  <= (w_nxt == IDLE);
         r_cvld <= (w_nxt == HOLD);

         if (w_acc) begin
            r_sh  <= LOAD_DATA;
            r_cnt <= '0;
         end else if (r_state == SHIFT) begin
            // Zero fill means SI returns to 0 once the word has gone out.
            r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
            r_cap <= {r_cap[WIDTH-2:0], SO};
            if (!w_last) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign SD         = r_sd;
   assign SP         = r_sp;
   assign SI         = r_sh[WIDTH-1];
   assign LOAD_READY = r_rdy;
   assign CAP_VALID  = r_cvld;
   assign CAP_DATA   = r_cap;

endmodule

// File: tb/tb_fl1p3_scan_seq.sv
// tb_fl1p3_scan_seq: bench for fl1p3_scan_seq with a behavioural model of the scan chain.
// Expected capture words and chain contents are queued at each accept and
// compared when the capture handshake is seen.
module tb_fl1p3_scan_seq;

   localparam int W = 8;

   logic          CK = 1'b0;
   logic          CD = 1'b0;
   logic          LOAD_VALID = 1'b0;
   logic          LOAD_READY;
   logic [W-1:0]  LOAD_DATA = '0;
   logic          LOAD_MODE = 1'b0;
   logic          SD;
   logic          SP;
   logic          SI;
   logic          SO;
   logic          CAP_VALID;
   logic          CAP_READY = 1'b1;
   logic [W-1:0]  CAP_DATA;

   bit            ck_run = 1'b0;
   int            cyc = 0;
   int            n_tests = 0;
   int            n_fail = 0;

   // Chain model: flop k D1 = flop k-1, flop 0 D1 = SI, D0 = d0.
   logic [W-1:0]  chain = '0;
   logic [W-1:0]  d0 = 8'h5A;

   logic [W-1:0]  exp_cap_q[$];
   logic [W-1:0]  exp_chain_q[$];
   int            acc_q[$];

   fl1p3_scan_seq #(.WIDTH(W)) dut (
      .CK         (CK),
      .CD         (CD),
      .LOAD_VALID (LOAD_VALID),
      .LOAD_READY (LOAD_READY),
      .LOAD_DATA  (LOAD_DATA),
      .LOAD_MODE  (LOAD_MODE),
      .SD         (SD),
      .SP         (SP),
      .SI         (SI),
      .SO         (SO),
      .CAP_VALID  (CAP_VALID),
      .CAP_READY  (CAP_READY),
      .CAP_DATA   (CAP_DATA)
   );

   initial begin
      forever begin
         #5;
         if (ck_run) CK = ~CK;
      end
   end

   always @(posedge CK) begin
      cyc <= cyc + 1;
      if (SP) begin
         chain <= SD ? {chain[W-2:0], SI} : d0;
      end
   end

   assign SO = chain[W-1];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Inputs change at posedge+1, so values seen here hold through the next edge.
   always @(negedge CK) begin
      if (!CD && LOAD_VALID && LOAD_READY) begin
         acc_q.push_back(cyc + 1);
         exp_cap_q.push_back(LOAD_MODE ? d0 : chain);
         exp_chain_q.push_back(LOAD_DATA);
      end
      if (!CD && CAP_VALID && CAP_READY) begin
         if (exp_cap_q.size() == 0) begin
            chk("cap_unexpected", 32'(CAP_VALID), 32'd0);
         end else begin
            chk("cap_data", 32'(CAP_DATA), 32'(exp_cap_q.pop_front()));
            chk("chain", 32'(chain), 32'(exp_chain_q.pop_front()));
         end
      end
   end

   // Entered and left at posedge+1. Checks the chain control sequence.
   task automatic req(input logic [W-1:0] d, input logic m);
      int t;
      LOAD_VALID = 1'b1;
      LOAD_DATA  = d;
      LOAD_MODE  = m;
      t = 0;
      @(negedge CK);
      while (!LOAD_READY && t < 50) begin
         @(negedge CK);
         t++;
      end
      chk("accept_timeout", 32'(t < 50), 32'd1);
      @(posedge CK); #1;
      LOAD_VALID = 1'b0;
      LOAD_DATA  = W'($urandom);
      LOAD_MODE  = 1'($urandom);
      if (m) begin
         @(negedge CK);
         chk("capt_sd", 32'(SD), 32'd0);
         chk("capt_sp", 32'(SP), 32'd1);
      end
      for (int i = 0; i < W; i++) begin
         @(negedge CK);
         chk("shift_sd", 32'(SD), 32'd1);
         chk("shift_sp", 32'(SP), 32'd1);
         chk("shift_si", 32'(SI), 32'(d[W-1-i]));
         chk("shift_cvld", 32'(CAP_VALID), 32'd0);
      end
      @(negedge CK);
      chk("cvld_rise", 32'(CAP_VALID), 32'd1);
      chk("hold_sp", 32'(SP), 32'd0);
      chk("hold_si", 32'(SI), 32'd0);
      @(posedge CK); #1;
   endtask

   task automatic wait_cap();
      int t;
      t = 0;
      @(negedge CK);
      while (!CAP_VALID && t < 40) begin
         @(negedge CK);
         t++;
      end
      chk("cap_timeout", 32'(t < 40), 32'd1);
      @(posedge CK); #1;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_rdy"}, 32'(LOAD_READY), 32'd1);
      chk({tag, "_sd"}, 32'(SD), 32'd0);
      chk({tag, "_sp"}, 32'(SP), 32'd0);
      chk({tag, "_si"}, 32'(SI), 32'd0);
      chk({tag, "_cvld"}, 32'(CAP_VALID), 32'd0);
      chk({tag, "_cdat"}, 32'(CAP_DATA), 32'd0);
   endtask

   initial begin
      int th;
      int got;

      // Reset with the clock stopped: outputs must settle without an edge.
      #3 CD = 1'b1;
      #1 chk_reset_outs("rst");
      #2 CD = 1'b0;
      ck_run = 1'b1;
      @(posedge CK); #1;

      // Mode 0: first request loads 0x3C, second scans 0xA5 and returns 0x3C.
      req(8'h3C, 1'b0);
      req(8'hA5, 1'b0);

      // Mode 1: capture D0 = 0x5A, then scan 0x0F.
      d0 = 8'h5A;
      req(8'h0F, 1'b1);

      // Back-pressure: hold the result for 5 cycles with a new request pending.
      CAP_READY = 1'b0;
      req(8'h96, 1'b0);
      acc_q.delete();
      LOAD_VALID = 1'b1;
      LOAD_DATA  = 8'hC3;
      LOAD_MODE  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CK);
         chk("bp_cvld", 32'(CAP_VALID), 32'd1);
         chk("bp_cdat", 32'(CAP_DATA), 32'h0F);
         chk("bp_sp", 32'(SP), 32'd0);
         chk("bp_rdy", 32'(LOAD_READY), 32'd0);
      end
      @(posedge CK); #1;
      CAP_READY = 1'b1;
      @(negedge CK);
      chk("bp_rdy_at_hs", 32'(LOAD_READY), 32'd0);
      th = cyc + 1;
      @(negedge CK);
      chk("bp_rdy_after_hs", 32'(LOAD_READY), 32'd1);
      @(posedge CK); #1;
      LOAD_VALID = 1'b0;
      got = (acc_q.size() > 0) ? acc_q[0] : -1;
      chk("bp_reaccept_edge", 32'(got), 32'(th + 1));
      wait_cap();

      // Reset after three shift edges of a mode-0 request.
      LOAD_VALID = 1'b1;
      LOAD_DATA  = 8'h33;
      LOAD_MODE  = 1'b0;
      @(negedge CK);
      chk("mid_rdy", 32'(LOAD_READY), 32'd1);
      @(posedge CK); #1;
      LOAD_VALID = 1'b0;
      repeat (3) @(posedge CK);
      #2 CD = 1'b1;
      #1 chk_reset_outs("midrst");
      exp_cap_q.delete();
      exp_chain_q.delete();
      @(posedge CK); #1;
      chk("midrst_hold_sp", 32'(SP), 32'd0);
      CD = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CK);
         chk("midrst_no_cvld", 32'(CAP_VALID), 32'd0);
      end
      @(posedge CK); #1;
      req(8'hFF, 1'b0);

      // Back-to-back mode-0 requests: 10 cycles accept to accept.
      acc_q.delete();
      req(8'h12, 1'b0);
      req(8'hE7, 1'b0);
      req(8'h81, 1'b0);
      got = (acc_q.size() == 3) ? (acc_q[1] - acc_q[0]) : -1;
      chk("b2b_gap1", 32'(got), 32'd10);
      got = (acc_q.size() == 3) ? (acc_q[2] - acc_q[1]) : -1;
      chk("b2b_gap2", 32'(got), 32'd10);

      repeat (3) @(negedge CK);
      chk("sb_empty", 32'(exp_cap_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
